// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// hazard_ctrl_pkg : shared types and constants for the hazard controller
// Rev 1.0
// ============================================================================
package hazard_ctrl_pkg;

   localparam int          REG_W     = 5;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      HZ_RUN   = 2'd0,
      HZ_STALL = 2'd1,
      HZ_FLUSH = 2'd2
   } hz_state_e;

   // x0 is hard-wired zero, so a write to it can never create a dependency
   function automatic logic src_match(input logic [REG_W-1:0] rs,
                                      input logic             uses,
                                      input logic [REG_W-1:0] rd);
      return uses && (rd != '0) && (rs == rd);
   endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_if.sv
`default_nettype none
// ============================================================================
// hazard_if : pipeline-side signals observed and driven by hazard_ctrl
// Rev 1.0
// ============================================================================
interface hazard_if
   import hazard_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
);
   logic [REG_W-1:0] id_rs1;
   logic [REG_W-1:0] id_rs2;
   logic             id_uses_rs1;
   logic             id_uses_rs2;
   logic [REG_W-1:0] idex_rd;
   logic             idex_mem_read;
   logic             idex_reg_write;
   logic [REG_W-1:0] exmem_rd;
   logic             exmem_reg_write;
   logic             exmem_branch_taken;
   logic             pc_write;
   logic             pc_sel_branch;
   logic             ifid_write;
   logic             ifid_flush;
   logic             idex_bubble;
   logic             exmem_flush;
   logic [1:0]       hz_state;
   logic             hz_error;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, idex_rd, idex_mem_read,
             idex_reg_write, exmem_rd, exmem_reg_write, exmem_branch_taken,
      input  pc_write, pc_sel_branch, ifid_write, ifid_flush, idex_bubble,
             exmem_flush, hz_state, hz_error, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, idex_rd, idex_mem_read,
             idex_reg_write, exmem_rd, exmem_reg_write, exmem_branch_taken,
      output pc_write, pc_sel_branch, ifid_write, ifid_flush, idex_bubble,
             exmem_flush, hz_state, hz_error, stall_cnt, flush_cnt
   );

endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_perf_cnt.sv
`default_nettype none
// ============================================================================
// hazard_perf_cnt : saturating event counter
// Rev 1.0
// ============================================================================
module hazard_perf_cnt #(
   parameter int W = 32
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);
   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != '1)) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// hazard_ctrl : load-use/RAW stall and branch-redirect flush control with
//               stall watchdog; event counters built when HAZARD_CTRL_PERF_EN
// Rev 1.0
// ============================================================================
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int FORWARDING = 1,
   parameter int MAX_STALL  = 2,
   parameter int CNT_W      = 32
) (
   input  logic    clock,
   input  logic    reset,
   hazard_if.slave hz
);
   localparam int              WD_W     = $clog2(MAX_STALL + 2);
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MAX_STALL);

   logic            dep_idex;
   logic            dep_exmem;
   logic            load_use;
   logic            raw;
   logic            hazard;
   logic            redirect;
   logic            stall;
   hz_state_e       state_q;
   hz_state_e       state_d;
   logic [WD_W-1:0] wd_cnt_q;
   logic [WD_W-1:0] wd_cnt_d;
   logic            hz_error_q;
   logic            hz_error_d;

   always_comb begin
      dep_idex  = src_match(hz.id_rs1, hz.id_uses_rs1, hz.idex_rd)
                | src_match(hz.id_rs2, hz.id_uses_rs2, hz.idex_rd);
      dep_exmem = src_match(hz.id_rs1, hz.id_uses_rs1, hz.exmem_rd)
                | src_match(hz.id_rs2, hz.id_uses_rs2, hz.exmem_rd);
      load_use  = hz.idex_mem_read & dep_idex;
      raw       = load_use | (hz.idex_reg_write & dep_idex)
                | (hz.exmem_reg_write & dep_exmem);
      hazard    = (FORWARDING != 0) ? load_use : raw;
      redirect  = hz.exmem_branch_taken;
      // the stalled instruction is on the wrong path when a branch redirects
      stall     = hazard & ~redirect;
   end

   always_comb begin
      hz.pc_write      = 1'b1;
      hz.ifid_write    = 1'b1;
      hz.pc_sel_branch = 1'b0;
      hz.ifid_flush    = 1'b0;
      hz.idex_bubble   = 1'b0;
      hz.exmem_flush   = 1'b0;
      if (reset) begin
         hz.pc_write    = 1'b0;
         hz.ifid_write  = 1'b0;
         hz.idex_bubble = 1'b1;
      end else if (redirect) begin
         hz.pc_sel_branch = 1'b1;
         hz.ifid_flush    = 1'b1;
         hz.idex_bubble   = 1'b1;
         hz.exmem_flush   = 1'b1;
      end else if (stall) begin
         hz.pc_write    = 1'b0;
         hz.ifid_write  = 1'b0;
         hz.idex_bubble = 1'b1;
      end
   end

   always_comb begin
      state_d = HZ_RUN;
      if (redirect) begin
         state_d = HZ_FLUSH;
      end else if (stall) begin
         state_d = HZ_STALL;
      end
   end

   always_comb begin
      wd_cnt_d = '0;
      if (stall) begin
         wd_cnt_d = (wd_cnt_q == '1) ? wd_cnt_q : wd_cnt_q + WD_W'(1);
      end
      hz_error_d = hz_error_q | (wd_cnt_d > WD_LIMIT);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= HZ_RUN;
         wd_cnt_q   <= '0;
         hz_error_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wd_cnt_q   <= wd_cnt_d;
         hz_error_q <= hz_error_d;
      end
   end

   assign hz.hz_state = state_q;
   assign hz.hz_error = hz_error_q;

`ifdef HAZARD_CTRL_PERF_EN
   hazard_perf_cnt #(.W(CNT_W)) u_stall_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (stall),
      .count (hz.stall_cnt)
   );

   hazard_perf_cnt #(.W(CNT_W)) u_flush_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (redirect),
      .count (hz.flush_cnt)
   );
`else
   assign hz.stall_cnt = '0;
   assign hz.flush_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_hazard_ctrl : checks a forwarding (index 0) and a non-forwarding
//                  (index 1) hazard_ctrl against a behavioural model
// Rev 1.0
// ============================================================================
module tb_hazard_ctrl;
   localparam int MAX_STALL = 2;
   localparam logic [1:0] S_RUN = 2'd0, S_STALL = 2'd1, S_FLUSH = 2'd2;
   localparam logic [5:0] C_RESET = 6'b000010, C_STALL = 6'b000010;
   localparam logic [5:0] C_REDIR = 6'b111111, C_RUN   = 6'b101000;
`ifdef HAZARD_CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic clk, rst;
   logic [4:0] rs1, rs2, idex_rd, exmem_rd;
   logic u1, u2, mr, rw, erw, bt;
   int total = 0;
   int bad   = 0;

   hazard_if #(.CNT_W(32)) if_f ();
   hazard_if #(.CNT_W(4))  if_n ();

   hazard_ctrl #(.FORWARDING(1), .MAX_STALL(MAX_STALL), .CNT_W(32)) u_fwd (
      .clock(clk), .reset(rst), .hz(if_f));
   hazard_ctrl #(.FORWARDING(0), .MAX_STALL(MAX_STALL), .CNT_W(4)) u_nofwd (
      .clock(clk), .reset(rst), .hz(if_n));

   assign if_f.id_rs1 = rs1;           assign if_n.id_rs1 = rs1;
   assign if_f.id_rs2 = rs2;           assign if_n.id_rs2 = rs2;
   assign if_f.id_uses_rs1 = u1;       assign if_n.id_uses_rs1 = u1;
   assign if_f.id_uses_rs2 = u2;       assign if_n.id_uses_rs2 = u2;
   assign if_f.idex_rd = idex_rd;      assign if_n.idex_rd = idex_rd;
   assign if_f.idex_mem_read = mr;     assign if_n.idex_mem_read = mr;
   assign if_f.idex_reg_write = rw;    assign if_n.idex_reg_write = rw;
   assign if_f.exmem_rd = exmem_rd;    assign if_n.exmem_rd = exmem_rd;
   assign if_f.exmem_reg_write = erw;  assign if_n.exmem_reg_write = erw;
   assign if_f.exmem_branch_taken = bt; assign if_n.exmem_branch_taken = bt;

   logic [5:0]  o_ctl [2];
   logic [1:0]  o_st  [2];
   logic        o_err [2];
   logic [63:0] o_sc  [2];
   logic [63:0] o_fc  [2];
   assign o_ctl[0] = {if_f.pc_write, if_f.pc_sel_branch, if_f.ifid_write,
                      if_f.ifid_flush, if_f.idex_bubble, if_f.exmem_flush};
   assign o_ctl[1] = {if_n.pc_write, if_n.pc_sel_branch, if_n.ifid_write,
                      if_n.ifid_flush, if_n.idex_bubble, if_n.exmem_flush};
   assign o_st[0] = if_f.hz_state;  assign o_st[1] = if_n.hz_state;
   assign o_err[0] = if_f.hz_error; assign o_err[1] = if_n.hz_error;
   assign o_sc[0] = 64'(if_f.stall_cnt); assign o_sc[1] = 64'(if_n.stall_cnt);
   assign o_fc[0] = 64'(if_f.flush_cnt); assign o_fc[1] = 64'(if_n.flush_cnt);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic bit dep(input logic [4:0] rd);
      return (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
   endfunction

   function automatic bit stall_of(input int d);
      bit lu, h;
      lu = mr && dep(idex_rd);
      h  = (d == 0) ? lu : (lu || (rw && dep(idex_rd)) || (erw && dep(exmem_rd)));
      return h && !bt;
   endfunction

   function automatic logic [5:0] exp_ctl(input int d);
      if (rst) return C_RESET;
      if (bt) return C_REDIR;
      if (stall_of(d)) return C_STALL;
      return C_RUN;
   endfunction

   function automatic logic [63:0] sat(input logic [63:0] v, input int d);
      logic [63:0] cap;
      cap = (d == 0) ? 64'hFFFF_FFFF : 64'd15;
      return (v > cap) ? cap : v;
   endfunction

   logic [1:0]  m_st [2];
   bit          m_err [2];
   int          m_streak [2];
   logic [63:0] m_sc [2];
   logic [63:0] m_fc [2];

   always @(posedge clk or posedge rst) begin
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            m_st[d] <= S_RUN; m_err[d] <= 1'b0; m_streak[d] <= 0;
            m_sc[d] <= '0;    m_fc[d] <= '0;
         end else begin
            m_st[d] <= bt ? S_FLUSH : (stall_of(d) ? S_STALL : S_RUN);
            m_streak[d] <= stall_of(d) ? m_streak[d] + 1 : 0;
            if (stall_of(d) && (m_streak[d] + 1 > MAX_STALL)) m_err[d] <= 1'b1;
            if (stall_of(d)) m_sc[d] <= sat(m_sc[d] + 1, d);
            if (bt) m_fc[d] <= sat(m_fc[d] + 1, d);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_in(input logic [4:0] a_rs1, input logic a_u1,
                         input logic [4:0] a_rs2, input logic a_u2,
                         input logic [4:0] a_idrd, input logic a_mr, input logic a_rw,
                         input logic [4:0] a_exrd, input logic a_erw, input logic a_bt);
      rs1 = a_rs1; u1 = a_u1; rs2 = a_rs2; u2 = a_u2;
      idex_rd = a_idrd; mr = a_mr; rw = a_rw;
      exmem_rd = a_exrd; erw = a_erw; bt = a_bt;
   endtask

   task automatic idle();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; idle();
      @(negedge clk); #1;
      for (int d = 0; d < 2; d++) begin
         total++; if (o_ctl[d] !== C_RESET) begin bad++; $display("FAIL reset_ctl[%0d]: got %b want %b", d, o_ctl[d], C_RESET); end
         total++; if (o_st[d] !== S_RUN) begin bad++; $display("FAIL reset_state[%0d]: got %0d want 0", d, o_st[d]); end
         total++; if (o_err[d] !== 1'b0) begin bad++; $display("FAIL reset_err[%0d]: got %b want 0", d, o_err[d]); end
         total++; if (o_sc[d] !== 64'd0 || o_fc[d] !== 64'd0) begin bad++; $display("FAIL reset_cnt[%0d]: got %0d/%0d want 0/0", d, o_sc[d], o_fc[d]); end
      end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_load_use();
      @(negedge clk); set_in(5, 1, 0, 0, 5, 1, 1, 0, 0, 0); #1;
      total++; if (o_ctl[0] !== C_STALL) begin bad++; $display("FAIL lu_ctl: got %b want %b", o_ctl[0], C_STALL); end
      @(negedge clk);
      total++; if (o_st[0] !== S_STALL) begin bad++; $display("FAIL lu_state: got %0d want 1", o_st[0]); end
      set_in(5, 1, 0, 0, 0, 0, 0, 5, 1, 0); #1;
      total++; if (o_ctl[0] !== C_RUN) begin bad++; $display("FAIL lu_advanced_ctl: got %b want %b", o_ctl[0], C_RUN); end
      total++; if (o_ctl[1] !== C_STALL) begin bad++; $display("FAIL nofwd_exmem_ctl: got %b want %b", o_ctl[1], C_STALL); end
      @(negedge clk);
      total++; if (o_st[0] !== S_RUN) begin bad++; $display("FAIL lu_back_run: got %0d want 0", o_st[0]); end
      idle();
   endtask

   task automatic test_no_stall();
      @(negedge clk); set_in(5, 1, 0, 0, 0, 1, 1, 0, 0, 0); #1;
      for (int d = 0; d < 2; d++) begin
         total++; if (o_ctl[d] !== C_RUN) begin bad++; $display("FAIL x0_nostall[%0d]: got %b want %b", d, o_ctl[d], C_RUN); end
      end
      @(negedge clk); set_in(5, 0, 0, 0, 5, 1, 1, 0, 0, 0); #1;
      for (int d = 0; d < 2; d++) begin
         total++; if (o_ctl[d] !== C_RUN) begin bad++; $display("FAIL unused_nostall[%0d]: got %b want %b", d, o_ctl[d], C_RUN); end
      end
      idle();
   endtask

   task automatic test_redirect_priority();
      logic [63:0] pre_sc, pre_fc;
      @(negedge clk);
      pre_sc = m_sc[0]; pre_fc = m_fc[0];
      set_in(5, 1, 0, 0, 5, 1, 1, 0, 0, 1); #1;
      total++; if (o_ctl[0] !== C_REDIR) begin bad++; $display("FAIL redir_ctl: got %b want %b", o_ctl[0], C_REDIR); end
      @(negedge clk);
      total++; if (o_st[0] !== S_FLUSH) begin bad++; $display("FAIL redir_state: got %0d want 2", o_st[0]); end
      total++; if (o_sc[0] !== (PERF ? pre_sc : 64'd0)) begin bad++; $display("FAIL redir_stall_cnt: got %0d want %0d", o_sc[0], PERF ? pre_sc : 64'd0); end
      total++; if (o_fc[0] !== (PERF ? pre_fc + 1 : 64'd0)) begin bad++; $display("FAIL redir_flush_cnt: got %0d want %0d", o_fc[0], PERF ? pre_fc + 1 : 64'd0); end
      idle();
   endtask

   task automatic test_nofwd_raw();
      logic [63:0] pre_sc, want;
      @(negedge clk);
      pre_sc = m_sc[1];
      set_in(0, 0, 7, 1, 7, 0, 1, 0, 0, 0); #1;
      total++; if (o_ctl[1] !== C_STALL) begin bad++; $display("FAIL raw_c1_ctl: got %b want %b", o_ctl[1], C_STALL); end
      total++; if (o_ctl[0] !== C_RUN) begin bad++; $display("FAIL raw_fwd_ctl: got %b want %b", o_ctl[0], C_RUN); end
      @(negedge clk);
      total++; if (o_st[1] !== S_STALL) begin bad++; $display("FAIL raw_c1_state: got %0d want 1", o_st[1]); end
      set_in(0, 0, 7, 1, 7, 0, 0, 7, 1, 0); #1;
      total++; if (o_ctl[1] !== C_STALL) begin bad++; $display("FAIL raw_c2_ctl: got %b want %b", o_ctl[1], C_STALL); end
      @(negedge clk);
      total++; if (o_st[1] !== S_STALL) begin bad++; $display("FAIL raw_c2_state: got %0d want 1", o_st[1]); end
      set_in(0, 0, 7, 1, 0, 0, 0, 0, 0, 0); #1;
      total++; if (o_ctl[1] !== C_RUN) begin bad++; $display("FAIL raw_done_ctl: got %b want %b", o_ctl[1], C_RUN); end
      @(negedge clk);
      want = PERF ? sat(pre_sc + 2, 1) : 64'd0;
      total++; if (o_st[1] !== S_RUN) begin bad++; $display("FAIL raw_run_state: got %0d want 0", o_st[1]); end
      total++; if (o_sc[1] !== want) begin bad++; $display("FAIL raw_stall_cnt: got %0d want %0d", o_sc[1], want); end
      idle();
   endtask

   task automatic test_watchdog();
      do_reset();
      set_in(5, 1, 0, 0, 5, 1, 1, 0, 0, 0);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            total++; if (o_err[d] !== (k >= 3)) begin bad++; $display("FAIL wd_err[%0d] after %0d stalls: got %b want %b", d, k, o_err[d], k >= 3); end
         end
      end
      idle();
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         total++; if (o_err[d] !== 1'b1) begin bad++; $display("FAIL wd_sticky[%0d]: got %b want 1", d, o_err[d]); end
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk); set_in(5, 1, 0, 0, 5, 1, 1, 0, 0, 0);
      @(negedge clk);
      total++; if (o_st[0] !== S_STALL) begin bad++; $display("FAIL ar_pre_state: got %0d want 1", o_st[0]); end
      #1 rst = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         total++; if (o_ctl[d] !== C_RESET) begin bad++; $display("FAIL ar_ctl[%0d]: got %b want %b", d, o_ctl[d], C_RESET); end
         total++; if (o_st[d] !== S_RUN || o_err[d] !== 1'b0) begin bad++; $display("FAIL ar_state_err[%0d]: got %0d/%b want 0/0", d, o_st[d], o_err[d]); end
         total++; if (o_sc[d] !== 64'd0 || o_fc[d] !== 64'd0) begin bad++; $display("FAIL ar_cnt[%0d]: got %0d/%0d want 0/0", d, o_sc[d], o_fc[d]); end
      end
      @(negedge clk); rst = 1'b0; #1;
      total++; if (o_ctl[0] !== C_STALL || o_st[0] !== S_RUN) begin bad++; $display("FAIL ar_release: got %b/%0d want %b/0", o_ctl[0], o_st[0], C_STALL); end
      @(negedge clk);
      total++; if (o_st[0] !== S_STALL || o_err[0] !== 1'b0) begin bad++; $display("FAIL ar_first_stall: got %0d/%b want 1/0", o_st[0], o_err[0]); end
      idle();
      do_reset();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         set_in(5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
                5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom_range(0, 5) == 0));
         #1;
         for (int d = 0; d < 2; d++) begin
            total++; if (o_ctl[d] !== exp_ctl(d)) begin bad++; $display("FAIL rnd_ctl[%0d] cyc %0d: got %b want %b", d, c, o_ctl[d], exp_ctl(d)); end
            total++; if (o_st[d] !== m_st[d]) begin bad++; $display("FAIL rnd_state[%0d] cyc %0d: got %0d want %0d", d, c, o_st[d], m_st[d]); end
            total++; if (o_err[d] !== m_err[d]) begin bad++; $display("FAIL rnd_err[%0d] cyc %0d: got %b want %b", d, c, o_err[d], m_err[d]); end
            total++; if (o_sc[d] !== (PERF ? m_sc[d] : 64'd0)) begin bad++; $display("FAIL rnd_stall_cnt[%0d] cyc %0d: got %0d want %0d", d, c, o_sc[d], PERF ? m_sc[d] : 64'd0); end
            total++; if (o_fc[d] !== (PERF ? m_fc[d] : 64'd0)) begin bad++; $display("FAIL rnd_flush_cnt[%0d] cyc %0d: got %0d want %0d", d, c, o_fc[d], PERF ? m_fc[d] : 64'd0); end
         end
      end
      idle();
   endtask

   initial begin
      rst = 1'b1;
      idle();
      test_reset();
      test_load_use();
      test_no_stall();
      test_redirect_priority();
      test_nofwd_raw();
      test_watchdog();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
